// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cacheline_adaptor : splits/assembles a cacheline into BEATS memory bursts.
// Optional CLA_FAST_RESP_EN: respond in the final beat's cycle, skipping DONE.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cacheline_adaptor #(
   parameter int BURST_W = 64,
   parameter int BEATS   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [BURST_W*BEATS-1:0]   line_i,
   output logic [BURST_W*BEATS-1:0]   line_o,
   input  logic [31:0]                address_i,
   input  logic                       read_i,
   input  logic                       write_i,
   output logic                       resp_o,
   input  logic [BURST_W-1:0]         burst_i,
   output logic [BURST_W-1:0]         burst_o,
   output logic [31:0]                address_o,
   output logic                       read_o,
   output logic                       write_o,
   input  logic                       resp_i
);

   localparam int              LW        = BURST_W * BEATS;
   localparam int              CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int              OFF_W     = $clog2(LW / 8);
   localparam logic [CW-1:0]   LAST      = CW'(BEATS - 1);
   localparam logic [31:0]     ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     addr_q, addr_d;
   logic [LW-1:0]   wline_q, wline_d;
   logic [LW-1:0]   rline_q, rline_d;
   logic            read_q, read_d;
   logic            write_q, write_d;
`ifndef CLA_FAST_RESP_EN
   logic            resp_q, resp_d;
`endif
   logic            w_last_beat;

   assign w_last_beat = resp_i && (cnt_q == LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wline_d = wline_q;
      rline_d = rline_q;
      read_d  = read_q;
      write_d = write_q;
`ifndef CLA_FAST_RESP_EN
      resp_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (read_i) begin
               state_d = READ;
               addr_d  = address_i;
               cnt_d   = '0;
               read_d  = 1'b1;
            end else if (write_i) begin
               state_d = WRITE;
               addr_d  = address_i;
               wline_d = line_i;
               cnt_d   = '0;
               write_d = 1'b1;
            end
         end
         READ, WRITE: begin
            if (resp_i) begin
               if (state_q == READ) begin
                  rline_d[cnt_q*BURST_W +: BURST_W] = burst_i;
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  read_d  = 1'b0;
                  write_d = 1'b0;
`ifdef CLA_FAST_RESP_EN
                  state_d = IDLE;
`else
                  state_d = DONE;
                  resp_d  = 1'b1;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
`ifndef CLA_FAST_RESP_EN
         resp_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wline_q <= wline_d;
         rline_q <= rline_d;
         read_q  <= read_d;
         write_q <= write_d;
`ifndef CLA_FAST_RESP_EN
         resp_q  <= resp_d;
`endif
      end
   end

   assign read_o    = read_q;
   assign write_o   = write_q;
   assign address_o = addr_q & ADDR_MASK;

   always_comb begin
      burst_o = '0;
      if (state_q == WRITE) begin
         burst_o = wline_q[cnt_q*BURST_W +: BURST_W];
      end
   end

`ifdef CLA_FAST_RESP_EN
   assign resp_o = ((state_q == READ) || (state_q == WRITE)) && w_last_beat;

   // Final read beat is forwarded so line_o is complete in the resp_o cycle.
   always_comb begin
      line_o = rline_q;
      if ((state_q == READ) && w_last_beat) begin
         line_o[(BEATS-1)*BURST_W +: BURST_W] = burst_i;
      end
   end
`else
   assign resp_o = resp_q;
   assign line_o = rline_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cacheline_adaptor : randomized self-checking bench with a beat-level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cacheline_adaptor;

   localparam int BW = 64;
   localparam int NB = 4;
   localparam int LW = BW * NB;
`ifdef CLA_FAST_RESP_EN
   localparam int EXP_DELAY = 0;
`else
   localparam int EXP_DELAY = 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [LW-1:0]   line_i, line_o;
   logic [31:0]     address_i, address_o;
   logic            read_i, write_i, resp_o;
   logic [BW-1:0]   burst_i, burst_o;
   logic            read_o, write_o, resp_i;

   int n_vec  = 0;
   int n_miss = 0;
   logic [LW-1:0] last_read_line;

   cacheline_adaptor #(.BURST_W(BW), .BEATS(NB)) dut (
      .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
   );

   always #5 clk = ~clk;

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference: strobe cycles needed to collect NB accepted beats from a pattern.
   function automatic int strobe_len(input logic [31:0] pat);
      int ones = 0;
      int n = 0;
      while (ones < NB) begin
         if (n >= 32 || pat[n]) ones++;
         n++;
      end
      return n;
   endfunction

   // Drives one cache-side transaction and the memory side; returns observations.
   task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [LW-1:0] data, input logic [31:0] pat,
                          output logic [LW-1:0] line_at_resp, output logic [LW-1:0] line_after,
                          output logic [LW-1:0] wbeats, output logic [31:0] addr_seen,
                          output int strobes, output int resp_delay, output int resps,
                          output bit wr_seen, output bit timeout);
      int beat = 0, pidx = 0, last_cyc = -1, resp_cyc = -1;
      bit strobe, r;
      strobes = 0; resps = 0; wr_seen = 0; timeout = 1;
      wbeats = '0; addr_seen = '0; line_at_resp = '0; line_after = '0;
      read_i = rd; write_i = wr; address_i = addr; line_i = data;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (cyc > 0) begin
            address_i = $urandom;
            line_i    = rand_line();
         end
         strobe = read_o | write_o;
         if (strobe) begin
            r = (pidx >= 32) ? 1'b1 : pat[pidx];
            pidx++;
         end else begin
            r = 1'($urandom_range(0, 1));
         end
         resp_i  = r;
         burst_i = (strobe && r && rd && beat < NB) ? data[beat*BW +: BW]
                                                   : {$urandom, $urandom};
         @(negedge clk);
         wr_seen = wr_seen | write_o;
         if (strobe) begin
            strobes++;
            addr_seen = address_o;
         end
         if (strobe && r && beat < NB) begin
            wbeats[beat*BW +: BW] = burst_o;
            beat++;
            if (beat == NB) last_cyc = cyc;
         end
         if (resp_o) begin
            resps++;
            if (resp_cyc < 0) begin
               resp_cyc     = cyc;
               line_at_resp = line_o;
            end
         end
         if (resp_cyc >= 0 && cyc == resp_cyc + 2) begin
            line_after = line_o;
            timeout    = 0;
            break;
         end
         @(posedge clk); #1;
         if (resp_cyc >= 0) begin
            read_i  = 1'b0;
            write_i = 1'b0;
         end
      end
      @(posedge clk); #1;
      read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      resp_delay = (resp_cyc >= 0 && last_cyc >= 0) ? resp_cyc - last_cyc : -1;
   endtask

   task automatic test_reset();
      rst = 1'b1; read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
      address_i = 32'hFFFF_FFFF; line_i = rand_line(); burst_i = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec += 6;
      if (resp_o !== 1'b0)  begin n_miss++; $display("FAIL reset_resp_o got=%b exp=0", resp_o); end
      if (read_o !== 1'b0)  begin n_miss++; $display("FAIL reset_read_o got=%b exp=0", read_o); end
      if (write_o !== 1'b0) begin n_miss++; $display("FAIL reset_write_o got=%b exp=0", write_o); end
      if (burst_o !== '0)   begin n_miss++; $display("FAIL reset_burst_o got=%h exp=0", burst_o); end
      if (address_o !== '0) begin n_miss++; $display("FAIL reset_address_o got=%h exp=0", address_o); end
      if (line_o !== '0)    begin n_miss++; $display("FAIL reset_line_o got=%h exp=0", line_o); end
      @(posedge clk); #1;
      rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      last_read_line = '0;
   endtask

   task automatic test_read();
      logic [LW-1:0] la, lb, wb, data;
      logic [31:0] ad;
      int st, dl, rs;
      bit ws, to;
      data = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
      run_txn(1, 0, 32'h0000_1234, data, 32'hFFFF_FFFF, la, lb, wb, ad, st, dl, rs, ws, to);
      n_vec += 7;
      if (to !== 1'b0)          begin n_miss++; $display("FAIL read_timeout got=%b exp=0", to); end
      if (ad !== 32'h0000_1220) begin n_miss++; $display("FAIL read_address_o got=%h exp=00001220", ad); end
      if (la !== data)          begin n_miss++; $display("FAIL read_line got=%h exp=%h", la, data); end
      if (lb !== data)          begin n_miss++; $display("FAIL read_line_hold got=%h exp=%h", lb, data); end
      if (st !== 4)             begin n_miss++; $display("FAIL read_strobe_cycles got=%0d exp=4", st); end
      if (dl !== EXP_DELAY)     begin n_miss++; $display("FAIL read_resp_delay got=%0d exp=%0d", dl, EXP_DELAY); end
      if (rs !== 1)             begin n_miss++; $display("FAIL read_resp_count got=%0d exp=1", rs); end
      last_read_line = data;
   endtask

   task automatic test_write();
      logic [LW-1:0] la, lb, wb, data;
      logic [31:0] ad;
      int st, dl, rs;
      bit ws, to;
      data = 256'h0123456789ABCDEF_F0E1D2C3B4A59687_1122334455667788_FEDCBA9889ABCDEF;
      run_txn(0, 1, 32'h8000_0040, data, 32'hFFFF_FFFF, la, lb, wb, ad, st, dl, rs, ws, to);
      n_vec += 7;
      if (to !== 1'b0)            begin n_miss++; $display("FAIL write_timeout got=%b exp=0", to); end
      if (ad !== 32'h8000_0040)   begin n_miss++; $display("FAIL write_address_o got=%h exp=80000040", ad); end
      if (wb !== data)            begin n_miss++; $display("FAIL write_beats got=%h exp=%h", wb, data); end
      if (st !== 4)               begin n_miss++; $display("FAIL write_strobe_cycles got=%0d exp=4", st); end
      if (dl !== EXP_DELAY)       begin n_miss++; $display("FAIL write_resp_delay got=%0d exp=%0d", dl, EXP_DELAY); end
      if (rs !== 1)               begin n_miss++; $display("FAIL write_resp_count got=%0d exp=1", rs); end
      if (lb !== last_read_line)  begin n_miss++; $display("FAIL write_line_o_kept got=%h exp=%h", lb, last_read_line); end
      @(negedge clk);
      n_vec++;
      if (burst_o !== '0) begin n_miss++; $display("FAIL write_burst_idle got=%h exp=0", burst_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      logic [LW-1:0] la, lb, wb, data;
      logic [31:0] ad;
      int st, dl, rs;
      bit ws, to;
      data = rand_line();
      run_txn(1, 0, 32'h0000_2000, data, 32'h0000_0059, la, lb, wb, ad, st, dl, rs, ws, to);
      n_vec += 4;
      if (la !== data)      begin n_miss++; $display("FAIL stall_line got=%h exp=%h", la, data); end
      if (st !== 7)         begin n_miss++; $display("FAIL stall_strobe_cycles got=%0d exp=7", st); end
      if (dl !== EXP_DELAY) begin n_miss++; $display("FAIL stall_resp_delay got=%0d exp=%0d", dl, EXP_DELAY); end
      if (rs !== 1)         begin n_miss++; $display("FAIL stall_resp_count got=%0d exp=1", rs); end
      last_read_line = data;
   endtask

   task automatic test_contention();
      logic [LW-1:0] la, lb, wb, data;
      logic [31:0] ad;
      int st, dl, rs;
      bit ws, to;
      data = rand_line();
      run_txn(1, 1, 32'h0000_3000, data, $urandom, la, lb, wb, ad, st, dl, rs, ws, to);
      n_vec += 3;
      if (ws !== 1'b0) begin n_miss++; $display("FAIL contention_write_o got=%b exp=0", ws); end
      if (la !== data) begin n_miss++; $display("FAIL contention_line got=%h exp=%h", la, data); end
      if (rs !== 1)    begin n_miss++; $display("FAIL contention_resp_count got=%0d exp=1", rs); end
      last_read_line = data;
   endtask

   task automatic test_reset_mid();
      logic [LW-1:0] la, lb, wb, data;
      logic [31:0] ad;
      int st, dl, rs;
      bit ws, to;
      read_i = 1'b0; write_i = 1'b1; address_i = 32'h0000_4000; line_i = rand_line();
      @(posedge clk); #1;
      resp_i = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      @(negedge clk);
      n_vec += 3;
      if (write_o !== 1'b0) begin n_miss++; $display("FAIL rstmid_write_o got=%b exp=0", write_o); end
      if (resp_o !== 1'b0)  begin n_miss++; $display("FAIL rstmid_resp_o got=%b exp=0", resp_o); end
      if (burst_o !== '0)   begin n_miss++; $display("FAIL rstmid_burst_o got=%h exp=0", burst_o); end
      @(posedge clk); #1;
      data = rand_line();
      run_txn(1, 0, 32'h0000_5000, data, 32'hFFFF_FFFF, la, lb, wb, ad, st, dl, rs, ws, to);
      n_vec += 2;
      if (la !== data) begin n_miss++; $display("FAIL rstmid_next_read got=%h exp=%h", la, data); end
      if (st !== 4)    begin n_miss++; $display("FAIL rstmid_strobe_cycles got=%0d exp=4", st); end
      last_read_line = data;
   endtask

   task automatic test_random();
      logic [LW-1:0] la, lb, wb, data;
      logic [31:0] ad, addr, pat;
      int st, dl, rs;
      bit ws, to, rd;
      for (int t = 0; t < 24; t++) begin
         rd   = 1'($urandom_range(0, 1));
         addr = $urandom;
         data = rand_line();
         pat  = $urandom;
         run_txn(rd, !rd, addr, data, pat, la, lb, wb, ad, st, dl, rs, ws, to);
         n_vec += 5;
         if (rd ? (la !== data) : (wb !== data))
            begin n_miss++; $display("FAIL rand_data t=%0d rd=%b line=%h beats=%h exp=%h", t, rd, la, wb, data); end
         if (ad !== {addr[31:5], 5'b0})
            begin n_miss++; $display("FAIL rand_address t=%0d got=%h exp=%h", t, ad, {addr[31:5], 5'b0}); end
         if (st !== strobe_len(pat))
            begin n_miss++; $display("FAIL rand_strobe_cycles t=%0d got=%0d exp=%0d", t, st, strobe_len(pat)); end
         if (dl !== EXP_DELAY)
            begin n_miss++; $display("FAIL rand_resp_delay t=%0d got=%0d exp=%0d", t, dl, EXP_DELAY); end
         if (lb !== (rd ? data : last_read_line))
            begin n_miss++; $display("FAIL rand_line_hold t=%0d got=%h exp=%h", t, lb, rd ? data : last_read_line); end
         if (rd) last_read_line = data;
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_stall();
      test_contention();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
